// File: rtl/lcd_spi_arbiter.sv
// lcd_spi_arbiter
// ---------------
// Shares the single lcd_write SPI serializer between three word-level
// requesters:
//   0 = lcd_init
//   1 = lcd_show_char
//   2 = fill/rect drawer
//
// Arbitration and ownership:
//   - Round-robin arbitration happens only in IDLE.
//   - A grant is then locked for the whole burst, so command/data
//     streams never interleave.
//   - Only one word may be outstanding at a time.
//   - A watchdog guards the wr_done handshake.
//
// Parameters:
//   IDLE_GAP   - idle cycles inserted after a release before re-arbitration
//                (0 = none)
//   WDT_CYCLES - WAIT cycles allowed before a watchdog timeout (>= 2)
//
// Ports:
//   sys_clk, sys_rst_n     - clock, asynchronous active-low reset
//   init_done              - while low only requester 0 is eligible
//   req[2:0]               - per-requester burst request, held for the burst
//   wdata0/1/2[8:0]        - word from requester k (bit8 = DC, 7:0 = byte)
//   wen[2:0]               - per-requester one-cycle write strobe
//   gnt[2:0]               - one-hot grant
//   wdone[2:0]             - completion routed to the owner
//   data[8:0]              - word to lcd_write
//   en_write               - one-cycle write strobe to lcd_write
//   wr_done                - lcd_write completion pulse
//   busy                   - grant held or inter-burst gap in progress
//   timeout_err            - sticky watchdog flag
//   ovf_err                - sticky: owner strobed wen with a word outstanding
//
// Optional feature (macro LCD_ARB_STATS_EN):
//   word_cnt[15:0]  - counts en_write pulses (wrapping)
//   burst_cnt[7:0]  - counts grants (wrapping)

module lcd_spi_arbiter #(
  parameter int IDLE_GAP   = 2,
  parameter int WDT_CYCLES = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_done,
  input  logic [2:0]  req,
  input  logic [8:0]  wdata0,
  input  logic [8:0]  wdata1,
  input  logic [8:0]  wdata2,
  input  logic [2:0]  wen,
  output logic [2:0]  gnt,
  output logic [2:0]  wdone,
  output logic [8:0]  data,
  output logic        en_write,
  input  logic        wr_done,
  output logic        busy,
  output logic        timeout_err,
  output logic        ovf_err
`ifdef LCD_ARB_STATS_EN
  ,
  output logic [15:0] word_cnt,
  output logic [7:0]  burst_cnt
`endif
);

  localparam int WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t state, next_state;

  logic [1:0]       rr_ptr;
  logic [WDT_W-1:0] wdog;
  logic [GAP_W-1:0] gap_cnt;

  logic [2:0] eligible;
  logic [1:0] p0, p1, p2;
  logic [1:0] win_idx;
  logic       win_valid;

  logic [8:0] owner_wdata;
  logic       owner_wen;
  logic       owner_req;

  logic grant_now;
  logic issue;
  logic release_now;
  logic ovf_set;
  logic expire;
  logic wdog_inc;
  logic done_pulse;

  // The owner is identified directly by the one-hot grant, so the owner's
  // strobe, request and word are simple AND-OR selects.
  assign owner_wen   = |(wen & gnt);
  assign owner_req   = |(req & gnt);
  assign owner_wdata = ({9{gnt[0]}} & wdata0)
                     | ({9{gnt[1]}} & wdata1)
                     | ({9{gnt[2]}} & wdata2);

  assign eligible = req & (init_done ? 3'b111 : 3'b001);

  // Search order starts one past the last winner, wrapping modulo 3.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (rr_ptr)
      2'd0: begin
        p0 = 2'd1;
        p1 = 2'd2;
        p2 = 2'd0;
      end
      2'd1: begin
        p0 = 2'd2;
        p1 = 2'd0;
        p2 = 2'd1;
      end
      default: begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
      end
    endcase
  end

  always_comb begin
    win_valid = 1'b1;
    win_idx   = p0;
    if (eligible[p0]) begin
      win_idx = p0;
    end else if (eligible[p1]) begin
      win_idx = p1;
    end else if (eligible[p2]) begin
      win_idx = p2;
    end else begin
      win_valid = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control strobes. A req drop is only honoured
  // in OWN when no write is issued the same cycle, and in WAIT only once
  // the word has completed (real wr_done or watchdog expiry). A genuine
  // wr_done in the expiry cycle wins and suppresses the error.
  always_comb begin
    next_state  = state;
    grant_now   = 1'b0;
    issue       = 1'b0;
    release_now = 1'b0;
    ovf_set     = 1'b0;
    expire      = 1'b0;
    wdog_inc    = 1'b0;
    done_pulse  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          grant_now  = 1'b1;
          next_state = ST_OWN;
        end
      end
      ST_OWN: begin
        if (owner_wen) begin
          issue      = 1'b1;
          next_state = ST_WAIT;
        end else if (!owner_req) begin
          release_now = 1'b1;
          next_state  = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_WAIT: begin
        ovf_set = owner_wen;
        if (wr_done || (wdog == WDT_LAST)) begin
          done_pulse = 1'b1;
          expire     = !wr_done;
          if (owner_req) begin
            next_state = ST_OWN;
          end else begin
            release_now = 1'b1;
            next_state  = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
          end
        end else begin
          wdog_inc = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Late wr_done outside WAIT never reaches a requester.
  assign wdone = gnt & {3{done_pulse}};
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt    <= 3'b000;
      rr_ptr <= 2'd2;
    end else if (grant_now) begin
      gnt    <= 3'b001 << win_idx;
      rr_ptr <= win_idx;
    end else if (release_now) begin
      gnt <= 3'b000;
    end
  end

  // data keeps the last issued word between writes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data     <= 9'h000;
      en_write <= 1'b0;
    end else begin
      en_write <= issue;
      if (issue) begin
        data <= owner_wdata;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdog    <= '0;
      gap_cnt <= '0;
    end else begin
      if (issue) begin
        wdog <= '0;
      end else if (wdog_inc) begin
        wdog <= wdog + 1'b1;
      end
      if (release_now) begin
        gap_cnt <= '0;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timeout_err <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (expire) begin
        timeout_err <= 1'b1;
      end
      if (ovf_set) begin
        ovf_err <= 1'b1;
      end
    end
  end

`ifdef LCD_ARB_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      word_cnt  <= 16'd0;
      burst_cnt <= 8'd0;
    end else begin
      if (en_write) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (grant_now) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
